// File: rtl/d_latch_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : d_latch_checker                                            |
// | Description : Response monitor for a D latch under test. Samples D, E,   |
// |               Q and complement Q on a free-running clock, runs a golden  |
// |               latch model, flags value and complement errors and keeps   |
// |               saturating sample/error counters.                          |
// |               Optional macro CHK_FIRST_ERR_EN adds first-error capture   |
// |               outputs (first_err_valid, first_err_sample).               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module d_latch_checker #(
  parameter int CNT_W  = 16,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop_on_err,
  input  logic             d_obs,
  input  logic             e_obs,
  input  logic             q_obs,
  input  logic             qn_obs,
  output logic             busy,
  output logic             model_q,
  output logic             mismatch,
  output logic [1:0]       err_type,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] sample_count
`ifdef CHK_FIRST_ERR_EN
  ,
  output logic             first_err_valid,
  output logic [CNT_W-1:0] first_err_sample
`endif
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_UNKNOWN = 2'd1,
    S_CHECK   = 2'd2,
    S_HALT    = 2'd3
  } state_t;

  localparam logic [3:0]       c_settle_init = 4'(SETTLE);
  localparam logic [CNT_W-1:0] c_cnt_max     = '1;
  localparam logic [CNT_W-1:0] c_cnt_one     = CNT_W'(1);

  state_t           state_q, state_d;
  logic             first_q, first_d;      // first sampling cycle after start
  logic             d_prev_q, e_prev_q;
  logic [3:0]       settle_q, settle_d;
  logic             model_st_q, model_st_d;
  logic             mismatch_q, mismatch_d;
  logic [1:0]       err_type_q, err_type_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] smp_cnt_q, smp_cnt_d;
`ifdef CHK_FIRST_ERR_EN
  logic             fev_q, fev_d;
  logic [CNT_W-1:0] fes_q, fes_d;
`endif

  logic             w_changed;
  logic [3:0]       w_settle_nxt;
  logic             w_active;
  logic             w_val_cmp;
  logic             w_q_err;
  logic             w_c_err;
  logic             w_err;

  // Any movement on the D/E pair restarts the settle window.
  assign w_changed    = (d_obs != d_prev_q) || (e_obs != e_prev_q);
  assign w_settle_nxt = w_changed ? c_settle_init :
                        ((settle_q == 4'd0) ? 4'd0 : settle_q - 4'd1);

  assign w_active  = (state_q == S_UNKNOWN) || (state_q == S_CHECK);
  // Value compare needs a defined model and a D/E pair stable long enough.
  assign w_val_cmp = (state_q == S_CHECK) && (w_settle_nxt == 4'd0);
  assign w_q_err   = w_val_cmp && (q_obs != model_st_q);
  // The very first sample after arming is observation only.
  assign w_c_err   = w_active && !first_q && (qn_obs == q_obs);
  assign w_err     = w_q_err || w_c_err;

  // Next-state, model, error reporting and counter update.
  always_comb begin
    state_d    = state_q;
    first_d    = first_q;
    settle_d   = w_settle_nxt;
    model_st_d = model_st_q;
    mismatch_d = 1'b0;
    err_type_d = err_type_q;
    err_cnt_d  = err_cnt_q;
    smp_cnt_d  = smp_cnt_q;
`ifdef CHK_FIRST_ERR_EN
    fev_d      = fev_q;
    fes_d      = fes_q;
`endif

    if (start) begin
      // start beats any error seen in the same cycle
      state_d    = S_UNKNOWN;
      first_d    = 1'b1;
      settle_d   = c_settle_init;
      err_type_d = 2'b00;
      err_cnt_d  = '0;
      smp_cnt_d  = '0;
`ifdef CHK_FIRST_ERR_EN
      fev_d      = 1'b0;
      fes_d      = '0;
`endif
    end else if (w_active) begin
      first_d = 1'b0;
      if (w_val_cmp && (smp_cnt_q != c_cnt_max)) begin
        smp_cnt_d = smp_cnt_q + c_cnt_one;
      end
      if (e_obs) begin
        model_st_d = d_obs;
      end
      if (w_err) begin
        mismatch_d = 1'b1;
        err_type_d = {w_c_err, w_q_err};
        if (err_cnt_q != c_cnt_max) begin
          err_cnt_d = err_cnt_q + c_cnt_one;
        end
`ifdef CHK_FIRST_ERR_EN
        if (!fev_q) begin
          fev_d = 1'b1;
          fes_d = smp_cnt_q;
        end
`endif
      end
      if (w_err && stop_on_err) begin
        state_d = S_HALT;
      end else if ((state_q == S_UNKNOWN) && e_obs) begin
        state_d = S_CHECK;
      end
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      first_q    <= 1'b0;
      d_prev_q   <= 1'b0;
      e_prev_q   <= 1'b0;
      settle_q   <= c_settle_init;
      model_st_q <= 1'b0;
      mismatch_q <= 1'b0;
      err_type_q <= 2'b00;
      err_cnt_q  <= '0;
      smp_cnt_q  <= '0;
`ifdef CHK_FIRST_ERR_EN
      fev_q      <= 1'b0;
      fes_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      first_q    <= first_d;
      d_prev_q   <= d_obs;
      e_prev_q   <= e_obs;
      settle_q   <= settle_d;
      model_st_q <= model_st_d;
      mismatch_q <= mismatch_d;
      err_type_q <= err_type_d;
      err_cnt_q  <= err_cnt_d;
      smp_cnt_q  <= smp_cnt_d;
`ifdef CHK_FIRST_ERR_EN
      fev_q      <= fev_d;
      fes_q      <= fes_d;
`endif
    end
  end

  assign busy         = w_active;
  assign model_q      = model_st_q;
  assign mismatch     = mismatch_q;
  assign err_type     = err_type_q;
  assign err_count    = err_cnt_q;
  assign sample_count = smp_cnt_q;
`ifdef CHK_FIRST_ERR_EN
  assign first_err_valid  = fev_q;
  assign first_err_sample = fes_q;
`endif

endmodule
`default_nettype wire
